counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
- Run controller for a free-running up-counter datapath.
- Latches a programmed period and sequences the count through start, run, hold and stop.
- Emits a terminal-count tick in one-shot or periodic mode.
- Sits between software-visible control strobes and the 8-bit counter/enable path. Downstream logic uses tick/done as timebase events.

Parameters:
- WIDTH, 8, counter and period width in bits.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a run; latches period and periodic.
- stop  input  1  abort the current run.
- hold  input  1  freeze count while high; run stays active.
- periodic  input  1  0 = one-shot, 1 = auto-reload; sampled only with an accepted start.
- period  input  WIDTH  terminal period P in cycles; 0 is illegal.
- count  output  WIDTH  current count value, registered.
- busy  output  1  high while a run is active (state RUN).
- tick  output  1  one-cycle pulse at terminal count, registered.
- done  output  1  sticky; set when a one-shot run completes, cleared by the next accepted start.

Behaviour:
- Decided: one clock domain (clock); reset_n is asynchronous and active-low.
- Reset (asynchronous on reset_n low, at any time including mid-run):
  - state IDLE.
  - count, busy, tick, done, and the latched period/mode all = 0.
  - After release, the first action occurs on the first rising edge with reset_n high.
- States:
  - IDLE.
  - RUN.
  - busy = (state == RUN), registered.
- IDLE:
  - start=1 with stop=0 and period!=0 at edge k:
    - Latch P=period and mode=periodic.
    - count←0, done←0, state←RUN.
  - start with period==0 is ignored: state, count and done are unchanged.
  - start and stop in the same cycle: stop wins and state stays IDLE.
- RUN, evaluated each edge in priority order:
  1. stop=1: state←IDLE, count←0, no tick, done unchanged. This applies even if terminal count occurs in the same cycle.
  2. hold=1: count holds, no tick.
  3. count==P-1 (terminal count):
     - tick←1.
     - count←0.
     - If mode=one-shot: state←IDLE, done←1.
     - If mode=periodic: remain in RUN.
  4. Otherwise: count←count+1.
- tick is 0 in every cycle not covered by rule 3.
- Latency: an accepted start at edge k produces the first tick visible after edge k+P.
  - Periodic mode then ticks every P cycles, plus any cycles spent in hold.
  - P=1 in periodic mode gives tick high every cycle with count stuck at 0.
- start while in RUN is ignored. A new period or mode requires stop then start.
- period and periodic inputs are don't-care outside an accepted start.
- Arithmetic is modulo 2^WIDTH. count never exceeds P-1, so no overflow is possible.
- P = 2^WIDTH-1 (255 at default width) is legal.

Optional Feature:
- Macro: COUNTER_SEQUENCER_PRESCALE_EN.
- When defined:
  - Adds input port prescale, 8 bits, latched together with P on an accepted start.
  - An internal prescale counter, cleared on start, issues an advance strobe once every prescale+1 cycles.
  - RUN rules 3 and 4 act only on strobe cycles; on other cycles count holds and tick is 0.
  - hold also freezes the prescale counter.
  - stop clears the prescale counter.
  - prescale=0 is cycle-identical to the build without the macro.
- When undefined: no prescale port; the count advances every non-hold RUN cycle.

Test Plan:
- Reset values: drive reset_n low mid-run with count=5 → count, busy, tick and done all 0 immediately (asynchronous), before the next edge; after release the block idles until a start.
- One-shot: period=4, periodic=0, start at edge k → count 1,2,3 at k+1..k+3; tick=1, done=1, busy=0, count=0 after k+4; done stays 1 until the next start.
- Periodic with hold: period=3, periodic=1, hold high for 2 cycles after count=1 → ticks at k+3 and k+8 (the second tick is delayed by the 2 hold cycles); busy remains 1 throughout.
- Stop priority: period=2, periodic=1, stop asserted in the cycle where count=1 → no tick, state IDLE, count=0. Separately, start+stop together in IDLE → stays IDLE.
- Illegal and ignored starts:
  - start with period=0 → busy stays 0, done unchanged.
  - start with period=9 while running P=5 → run continues with P=5.
- Prescale (macro defined): prescale=2, period=2, one-shot → count changes every 3 cycles; tick and done after edge k+6.

Source files
------------

// File: rtl/counter_sequencer.sv
// Run controller for a free-running up-counter: start/run/hold/stop with terminal tick.
// Optional prescaler enabled by defining COUNTER_SEQUENCER_PRESCALE_EN.
module counter_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             periodic,
  input  logic [WIDTH-1:0] period,
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
  input  logic [7:0]       prescale,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q;
  logic             accept;
  logic             adv;

  assign accept = start && !stop && (period != '0);

`ifdef COUNTER_SEQUENCER_PRESCALE_EN
  logic [7:0] ps_lim_q, ps_lim_d;
  logic [7:0] ps_cnt_q, ps_cnt_d;

  assign adv = (ps_cnt_q == ps_lim_q);

  always_comb begin
    ps_lim_d = ps_lim_q;
    ps_cnt_d = ps_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ps_lim_d = prescale;
          ps_cnt_d = '0;
        end
      end
      RUN: begin
        if (stop) begin
          ps_cnt_d = '0;
        end else if (!hold) begin
          ps_cnt_d = adv ? 8'd0 : ps_cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ps_lim_q <= '0;
      ps_cnt_q <= '0;
    end else begin
      ps_lim_q <= ps_lim_d;
      ps_cnt_q <= ps_cnt_d;
    end
  end
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          per_d   = period;
          mode_d  = periodic;
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // stop beats hold, which beats terminal count
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (hold || !adv) begin
          cnt_d = cnt_q;
        end else if (cnt_q == per_q - ONE) begin
          tick_d = 1'b1;
          cnt_d  = '0;
          if (!mode_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      busy_q  <= (state_d == RUN);
    end
  end

  assign count = cnt_q;
  assign busy  = busy_q;
  assign tick  = tick_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: expected outputs are queued
// with each stimulus cycle and popped after the clock edge.
module tb_counter_sequencer;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       hold;
    logic       periodic;
    logic [7:0] period;
  } stim_t;

  typedef struct packed {
    logic [7:0] count;
    logic       busy;
    logic       tick;
    logic       done;
  } obs_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       hold = 1'b0;
  logic       periodic = 1'b0;
  logic [7:0] period = 8'd0;
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
  logic [7:0] prescale = 8'd0;
`endif
  logic [7:0] count;
  logic       busy;
  logic       tick;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  stim_t st[$];
  obs_t  sb[$];

  counter_sequencer #(.WIDTH(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .hold     (hold),
    .periodic (periodic),
    .period   (period),
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
    .prescale (prescale),
`endif
    .count    (count),
    .busy     (busy),
    .tick     (tick),
    .done     (done)
  );

  always #5 clock = ~clock;

  function automatic obs_t observe();
    return {count, busy, tick, done};
  endfunction

  task automatic add(input stim_t s, input obs_t e);
    st.push_back(s);
    sb.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    start    = s.start;
    stop     = s.stop;
    hold     = s.hold;
    periodic = s.periodic;
    period   = s.period;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    obs_t g;
    obs_t e;
    #3;
    sb.push_back('0);
    g = observe();
    e = sb.pop_front();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL reset_init got=%h exp=%h", g, e);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    add({1'b1, 1'b0, 1'b0, 1'b0, 8'd8}, {8'd0, 1'b1, 1'b0, 1'b0});
    for (int i = 1; i <= 5; i++)
      add({4'b0000, 8'd8}, {8'(i), 1'b1, 1'b0, 1'b0});
    while (st.size() > 0) begin
      apply(st.pop_front());
      g = observe();
      e = sb.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL reset_prerun got cnt=%0d b=%b t=%b d=%b exp cnt=%0d b=%b t=%b d=%b",
                 g.count, g.busy, g.tick, g.done, e.count, e.busy, e.tick, e.done);
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    sb.push_back('0);
    g = observe();
    e = sb.pop_front();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL reset_async got=%h exp=%h", g, e);
    end
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++)
      add({4'b0000, 8'd8}, '0);
    while (st.size() > 0) begin
      apply(st.pop_front());
      g = observe();
      e = sb.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL reset_idle got=%h exp=%h", g, e);
      end
    end
  endtask

  task automatic test_one_shot();
    obs_t g;
    obs_t e;
    add({1'b1, 1'b0, 1'b0, 1'b0, 8'd4}, {8'd0, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd1, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd2, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd3, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd0, 1'b0, 1'b1, 1'b1});
    add({4'b0000, 8'd0}, {8'd0, 1'b0, 1'b0, 1'b1});
    add({4'b0000, 8'd0}, {8'd0, 1'b0, 1'b0, 1'b1});
    for (int i = 0; st.size() > 0; i++) begin
      apply(st.pop_front());
      g = observe();
      e = sb.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL one_shot step %0d got cnt=%0d b=%b t=%b d=%b exp cnt=%0d b=%b t=%b d=%b",
                 i, g.count, g.busy, g.tick, g.done, e.count, e.busy, e.tick, e.done);
      end
    end
  endtask

  task automatic test_periodic_hold();
    obs_t g;
    obs_t e;
    add({1'b1, 1'b0, 1'b0, 1'b1, 8'd3}, {8'd0, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd1, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd2, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd0, 1'b1, 1'b1, 1'b0});
    add({4'b0000, 8'd0}, {8'd1, 1'b1, 1'b0, 1'b0});
    add({4'b0010, 8'd0}, {8'd1, 1'b1, 1'b0, 1'b0});
    add({4'b0010, 8'd0}, {8'd1, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd2, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd0, 1'b1, 1'b1, 1'b0});
    add({4'b0000, 8'd0}, {8'd1, 1'b1, 1'b0, 1'b0});
    add({4'b0100, 8'd0}, {8'd0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; st.size() > 0; i++) begin
      apply(st.pop_front());
      g = observe();
      e = sb.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL periodic_hold step %0d got cnt=%0d b=%b t=%b d=%b exp cnt=%0d b=%b t=%b d=%b",
                 i, g.count, g.busy, g.tick, g.done, e.count, e.busy, e.tick, e.done);
      end
    end
  endtask

  task automatic test_stop_priority();
    obs_t g;
    obs_t e;
    add({1'b1, 1'b0, 1'b0, 1'b1, 8'd2}, {8'd0, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd1, 1'b1, 1'b0, 1'b0});
    add({4'b0100, 8'd0}, {8'd0, 1'b0, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd0, 1'b0, 1'b0, 1'b0});
    add({4'b1101, 8'd2}, {8'd0, 1'b0, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; st.size() > 0; i++) begin
      apply(st.pop_front());
      g = observe();
      e = sb.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL stop_priority step %0d got cnt=%0d b=%b t=%b d=%b exp cnt=%0d b=%b t=%b d=%b",
                 i, g.count, g.busy, g.tick, g.done, e.count, e.busy, e.tick, e.done);
      end
    end
  endtask

  task automatic test_ignored_starts();
    obs_t g;
    obs_t e;
    add({1'b1, 1'b0, 1'b0, 1'b0, 8'd1}, {8'd0, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd0, 1'b0, 1'b1, 1'b1});
    add({4'b1001, 8'd0}, {8'd0, 1'b0, 1'b0, 1'b1});
    add({4'b0000, 8'd0}, {8'd0, 1'b0, 1'b0, 1'b1});
    add({1'b1, 1'b0, 1'b0, 1'b1, 8'd5}, {8'd0, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd1, 1'b1, 1'b0, 1'b0});
    add({4'b1000, 8'd9}, {8'd2, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd3, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd4, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd0, 1'b1, 1'b1, 1'b0});
    add({4'b0000, 8'd0}, {8'd1, 1'b1, 1'b0, 1'b0});
    add({4'b0100, 8'd0}, {8'd0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; st.size() > 0; i++) begin
      apply(st.pop_front());
      g = observe();
      e = sb.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL ignored_starts step %0d got cnt=%0d b=%b t=%b d=%b exp cnt=%0d b=%b t=%b d=%b",
                 i, g.count, g.busy, g.tick, g.done, e.count, e.busy, e.tick, e.done);
      end
    end
  endtask

  task automatic test_period_one();
    obs_t g;
    obs_t e;
    add({1'b1, 1'b0, 1'b0, 1'b1, 8'd1}, {8'd0, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++)
      add({4'b0000, 8'd0}, {8'd0, 1'b1, 1'b1, 1'b0});
    add({4'b0100, 8'd0}, {8'd0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; st.size() > 0; i++) begin
      apply(st.pop_front());
      g = observe();
      e = sb.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL period_one step %0d got cnt=%0d b=%b t=%b d=%b exp cnt=%0d b=%b t=%b d=%b",
                 i, g.count, g.busy, g.tick, g.done, e.count, e.busy, e.tick, e.done);
      end
    end
  endtask

  task automatic test_max_period();
    obs_t g;
    obs_t e;
    add({1'b1, 1'b0, 1'b0, 1'b0, 8'd255}, {8'd0, 1'b1, 1'b0, 1'b0});
    for (int i = 1; i <= 254; i++)
      add({4'b0000, 8'd0}, {8'(i), 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd0, 1'b0, 1'b1, 1'b1});
    add({4'b0000, 8'd0}, {8'd0, 1'b0, 1'b0, 1'b1});
    for (int i = 0; st.size() > 0; i++) begin
      apply(st.pop_front());
      g = observe();
      e = sb.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL max_period step %0d got cnt=%0d b=%b t=%b d=%b exp cnt=%0d b=%b t=%b d=%b",
                 i, g.count, g.busy, g.tick, g.done, e.count, e.busy, e.tick, e.done);
      end
    end
  endtask

`ifdef COUNTER_SEQUENCER_PRESCALE_EN
  task automatic test_prescale();
    obs_t g;
    obs_t e;
    prescale = 8'd2;
    add({1'b1, 1'b0, 1'b0, 1'b0, 8'd2}, {8'd0, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd0, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd0, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd1, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd1, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd1, 1'b1, 1'b0, 1'b0});
    add({4'b0000, 8'd0}, {8'd0, 1'b0, 1'b1, 1'b1});
    for (int i = 0; st.size() > 0; i++) begin
      apply(st.pop_front());
      g = observe();
      e = sb.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL prescale step %0d got cnt=%0d b=%b t=%b d=%b exp cnt=%0d b=%b t=%b d=%b",
                 i, g.count, g.busy, g.tick, g.done, e.count, e.busy, e.tick, e.done);
      end
    end
    prescale = 8'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_one_shot();
    test_periodic_hold();
    test_stop_priority();
    test_ignored_starts();
    test_period_one();
    test_max_period();
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
    test_prescale();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
